rcv_stream_ctrl: RTL and testbench

Controller that sequences the UART receiver block from the host side. It detects data_ready, issues a one-cycle data_read acknowledge, and moves each received byte plus its parity bit into a DEPTH-entry show-ahead FIFO. It keeps saturating counters for framing errors, overrun errors and FIFO-full drops. It sits between the receiver block and the host/bus interface, so the host no longer has to service the single-byte receive buffer in real time.

---
 rtl/rcv_stream_ctrl.sv | 166 ++++++++++++++++
 tb/tb_rcv_stream_ctrl.sv | 479 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rcv_stream_ctrl.sv
// rcv_stream_ctrl: host-side sequencer for the UART receiver. It acknowledges each
// received byte with a one-cycle data_read pulse and moves {parity, byte} into a
// DEPTH-entry show-ahead FIFO, and it keeps saturating error and drop counters.
// Ports: clk/n_rst (async active-low); enable gates new transactions;
//   rx_data/even_parity_bit/data_ready/overrun_error/framing_error come from the receiver;
//   data_read acks the receiver; pop/clr_counts come from the host;
//   fifo_* expose the FIFO head and its status; *_cnt are the counters; busy = FSM not idle.
module rcv_stream_ctrl #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     enable,
    input  logic [7:0]               rx_data,
    input  logic                     data_ready,
    input  logic                     overrun_error,
    input  logic                     framing_error,
    input  logic                     even_parity_bit,
    output logic                     data_read,
    input  logic                     pop,
    input  logic                     clr_counts,
    output logic [7:0]               fifo_data,
    output logic                     fifo_parity,
    output logic                     fifo_empty,
    output logic                     fifo_full,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [CNT_W-1:0]         framing_err_cnt,
    output logic [CNT_W-1:0]         overrun_cnt,
    output logic [CNT_W-1:0]         drop_cnt,
    output logic                     busy
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {IDLE, READ, WAIT_CLR} state_t;

    state_t            state_q;
    logic              data_read_q;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic [8:0]        mem_q [DEPTH];
    logic              fe_q, ov_q;
    logic [CNT_W-1:0]  fe_cnt_q, fe_cnt_d;
    logic [CNT_W-1:0]  ov_cnt_q, ov_cnt_d;
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
    logic              push, pop_ok, push_ok, drop;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            data_read_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (enable && data_ready) begin
                        state_q     <= READ;
                        data_read_q <= 1'b1;
                    end
                end
                READ: begin
                    state_q     <= WAIT_CLR;
                    data_read_q <= 1'b0;
                end
                WAIT_CLR: begin
                    if (!data_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    data_read_q <= 1'b0;
                end
            endcase
        end
    end

    // Capture happens on the edge that leaves READ; a pop in the same
    // cycle frees a slot, so a full FIFO still accepts the byte.
    assign push    = (state_q == READ);
    assign pop_ok  = pop && (count_q != '0);
    assign push_ok = push && ((count_q != FULL_CNT) || pop_ok);
    assign drop    = push && !push_ok;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + 1'b1;
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    always_comb begin
        fe_cnt_d   = fe_cnt_q;
        ov_cnt_d   = ov_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if (clr_counts) begin
            fe_cnt_d   = '0;
            ov_cnt_d   = '0;
            drop_cnt_d = '0;
        end else begin
            if (framing_error && !fe_q && fe_cnt_q != CNT_MAX) begin
                fe_cnt_d = fe_cnt_q + 1'b1;
            end
            if (overrun_error && !ov_q && ov_cnt_q != CNT_MAX) begin
                ov_cnt_d = ov_cnt_q + 1'b1;
            end
            if (drop && drop_cnt_q != CNT_MAX) begin
                drop_cnt_d = drop_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            fe_q       <= 1'b0;
            ov_q       <= 1'b0;
            fe_cnt_q   <= '0;
            ov_cnt_q   <= '0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            fe_q       <= framing_error;
            ov_q       <= overrun_error;
            fe_cnt_q   <= fe_cnt_d;
            ov_cnt_q   <= ov_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Storage needs no reset: contents are only observed when count is non-zero.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= {even_parity_bit, rx_data};
        end
    end

    assign data_read       = data_read_q;
    assign busy            = (state_q != IDLE);
    assign fifo_data       = mem_q[rd_ptr_q][7:0];
    assign fifo_parity     = mem_q[rd_ptr_q][8];
    assign fifo_count      = count_q;
    assign fifo_empty      = (count_q == '0);
    assign fifo_full       = (count_q == FULL_CNT);
    assign framing_err_cnt = fe_cnt_q;
    assign overrun_cnt     = ov_cnt_q;
    assign drop_cnt        = drop_cnt_q;

endmodule

// File: tb/tb_rcv_stream_ctrl.sv
// tb_rcv_stream_ctrl: scenario tasks plus a randomized run against a
// queue-based reference of the receive controller.
module tb_rcv_stream_ctrl;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       n_rst = 1'b1;
    logic       enable = 1'b0;
    logic [7:0] rx_data = '0;
    logic       data_ready = 1'b0;
    logic       overrun_error = 1'b0;
    logic       framing_error = 1'b0;
    logic       even_parity_bit = 1'b0;
    logic       pop = 1'b0;
    logic       clr_counts = 1'b0;

    logic       data_read, fifo_parity, fifo_empty, fifo_full, busy;
    logic [7:0] fifo_data, framing_err_cnt, overrun_cnt, drop_cnt;
    logic [3:0] fifo_count;

    logic       s_dr, s_par, s_empty, s_full, s_busy;
    logic [7:0] s_data;
    logic [3:0] s_count;
    logic [1:0] s_fe, s_ov, s_drop;

    rcv_stream_ctrl #(.DEPTH(DEPTH), .CNT_W(8)) u_dut (
        .clk(clk), .n_rst(n_rst), .enable(enable), .rx_data(rx_data),
        .data_ready(data_ready), .overrun_error(overrun_error),
        .framing_error(framing_error), .even_parity_bit(even_parity_bit),
        .data_read(data_read), .pop(pop), .clr_counts(clr_counts),
        .fifo_data(fifo_data), .fifo_parity(fifo_parity),
        .fifo_empty(fifo_empty), .fifo_full(fifo_full),
        .fifo_count(fifo_count), .framing_err_cnt(framing_err_cnt),
        .overrun_cnt(overrun_cnt), .drop_cnt(drop_cnt), .busy(busy)
    );

    rcv_stream_ctrl #(.DEPTH(DEPTH), .CNT_W(2)) u_sat (
        .clk(clk), .n_rst(n_rst), .enable(enable), .rx_data(rx_data),
        .data_ready(data_ready), .overrun_error(overrun_error),
        .framing_error(framing_error), .even_parity_bit(even_parity_bit),
        .data_read(s_dr), .pop(pop), .clr_counts(clr_counts),
        .fifo_data(s_data), .fifo_parity(s_par),
        .fifo_empty(s_empty), .fifo_full(s_full),
        .fifo_count(s_count), .framing_err_cnt(s_fe),
        .overrun_cnt(s_ov), .drop_cnt(s_drop), .busy(s_busy)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors = 0;

    // Reference: FIFO as a queue, transaction progress as two flags,
    // counters as plain integers clamped at their maxima.
    int m_q[$];
    bit m_busy, m_ack, m_fe_p, m_ov_p;
    int m_fe, m_ov, m_drop, m_fe2, m_ov2, m_drop2;

    function automatic int sat(input int v, input int mx);
        return (v < mx) ? v + 1 : v;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_busy = 0; m_ack = 0; m_fe_p = 0; m_ov_p = 0;
        m_fe = 0; m_ov = 0; m_drop = 0;
        m_fe2 = 0; m_ov2 = 0; m_drop2 = 0;
    endtask

    task automatic model_update();
        bit pop_ok, room, dropped;
        pop_ok  = pop && (m_q.size() > 0);
        room    = (m_q.size() - int'(pop_ok)) < DEPTH;
        dropped = m_ack && !room;
        if (pop_ok) void'(m_q.pop_front());
        if (m_ack && room) m_q.push_back(int'({even_parity_bit, rx_data}));
        if (clr_counts) begin
            m_fe = 0; m_ov = 0; m_drop = 0;
            m_fe2 = 0; m_ov2 = 0; m_drop2 = 0;
        end else begin
            if (framing_error && !m_fe_p) begin
                m_fe = sat(m_fe, 255); m_fe2 = sat(m_fe2, 3);
            end
            if (overrun_error && !m_ov_p) begin
                m_ov = sat(m_ov, 255); m_ov2 = sat(m_ov2, 3);
            end
            if (dropped) begin
                m_drop = sat(m_drop, 255); m_drop2 = sat(m_drop2, 3);
            end
        end
        if (!m_busy) begin
            if (enable && data_ready) begin
                m_busy = 1; m_ack = 1;
            end
        end else if (m_ack) begin
            m_ack = 0;
        end else if (!data_ready) begin
            m_busy = 0;
        end
        m_fe_p = framing_error;
        m_ov_p = overrun_error;
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic p, output int pulses);
        pulses = 0;
        rx_data = b; even_parity_bit = p; data_ready = 1'b1;
        tick(); pulses += int'(data_read);
        tick(); pulses += int'(data_read);
        data_ready = 1'b0;
        tick(); pulses += int'(data_read);
    endtask

    task automatic test_reset();
        #2 n_rst = 1'b0;
        #1;
        model_reset();
        vectors++;
        if ({data_read, busy, fifo_empty, fifo_full} !== 4'b0010) begin
            errors++;
            $display("FAIL reset_flags got dr/busy/empty/full=%b want 0010",
                     {data_read, busy, fifo_empty, fifo_full});
        end
        vectors++;
        if ({fifo_count, framing_err_cnt, overrun_cnt, drop_cnt} !== 28'd0) begin
            errors++;
            $display("FAIL reset_counts got cnt=%0d fe=%0d ov=%0d drop=%0d want 0",
                     fifo_count, framing_err_cnt, overrun_cnt, drop_cnt);
        end
        @(negedge clk);
        n_rst = 1'b1;
    endtask

    task automatic test_single_byte();
        enable = 1'b1;
        rx_data = 8'hA5; even_parity_bit = 1'b0; data_ready = 1'b1;
        tick();
        vectors++;
        if (data_read !== 1'b1 || fifo_count !== 4'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_ack got dr=%b cnt=%0d busy=%b want 1 0 1",
                     data_read, fifo_count, busy);
        end
        data_ready = 1'b0;
        tick();
        vectors++;
        if (data_read !== 1'b0 || fifo_count !== 4'd1 || fifo_data !== 8'hA5
            || fifo_parity !== 1'b0 || fifo_empty !== 1'b0) begin
            errors++;
            $display("FAIL single_store got dr=%b cnt=%0d data=%h par=%b want 0 1 a5 0",
                     data_read, fifo_count, fifo_data, fifo_parity);
        end
        tick();
        vectors++;
        if (busy !== 1'b0 || data_read !== 1'b0) begin
            errors++;
            $display("FAIL single_idle got busy=%b dr=%b want 0 0", busy, data_read);
        end
        pop = 1'b1;
        tick();
        pop = 1'b0;
        vectors++;
        if (fifo_empty !== 1'b1 || fifo_count !== 4'd0) begin
            errors++;
            $display("FAIL single_pop got empty=%b cnt=%0d want 1 0", fifo_empty, fifo_count);
        end
    endtask

    task automatic test_fill_overflow();
        int total, p;
        logic [7:0] b;
        total = 0;
        clr_counts = 1'b1; tick(); clr_counts = 1'b0;
        for (int i = 0; i < 10; i++) begin
            b = 8'(i);
            send_byte(b, b[0], p);
            total += p;
            if (i == 7) begin
                vectors++;
                if (fifo_full !== 1'b1 || fifo_count !== 4'd8) begin
                    errors++;
                    $display("FAIL fill_full got full=%b cnt=%0d want 1 8", fifo_full, fifo_count);
                end
            end
        end
        vectors++;
        if (drop_cnt !== 8'd2 || total !== 10) begin
            errors++;
            $display("FAIL fill_drop got drop=%0d pulses=%0d want 2 10", drop_cnt, total);
        end
        for (int i = 0; i < 8; i++) begin
            b = 8'(i);
            vectors++;
            if (fifo_data !== b || fifo_parity !== b[0]) begin
                errors++;
                $display("FAIL fill_order[%0d] got %h/%b want %h/%b",
                         i, fifo_data, fifo_parity, b, b[0]);
            end
            pop = 1'b1; tick(); pop = 1'b0;
        end
        vectors++;
        if (fifo_empty !== 1'b1) begin
            errors++;
            $display("FAIL fill_drain got empty=%b want 1", fifo_empty);
        end
    endtask

    task automatic test_wrap();
        int exp_q[$];
        int p, drop0;
        logic [7:0] b;
        logic [7:0] want;
        drop0 = int'(drop_cnt);
        for (int i = 0; i < 7; i++) begin
            b = 8'h40 + 8'(i);
            send_byte(b, 1'b1, p);
            exp_q.push_back(int'(b));
        end
        for (int k = 0; k < 21; k++) begin
            b = 8'h80 + 8'(k);
            rx_data = b; even_parity_bit = b[1]; data_ready = 1'b1;
            tick();
            exp_q.push_back(int'(b));
            want = 8'(exp_q.pop_front());
            vectors++;
            if (fifo_data !== want) begin
                errors++;
                $display("FAIL wrap_order[%0d] got %h want %h", k, fifo_data, want);
            end
            // On the last pass the count starts at 8, so push meets pop while full.
            pop = 1'b1; tick(); pop = 1'b0;
            data_ready = 1'b0;
            vectors++;
            if (fifo_count < 4'd6 || fifo_count > 4'd8 || int'(drop_cnt) !== drop0) begin
                errors++;
                $display("FAIL wrap_count[%0d] got cnt=%0d drop=%0d want 6..8 %0d",
                         k, fifo_count, drop_cnt, drop0);
            end
            tick();
            if (k == 19) begin
                send_byte(8'hEE, 1'b0, p);
                exp_q.push_back(32'hEE);
                vectors++;
                if (fifo_full !== 1'b1) begin
                    errors++;
                    $display("FAIL wrap_full got full=%b want 1", fifo_full);
                end
            end
        end
        vectors++;
        if (fifo_count !== 4'd8 || int'(drop_cnt) !== drop0) begin
            errors++;
            $display("FAIL full_pushpop got cnt=%0d drop=%0d want 8 %0d",
                     fifo_count, drop_cnt, drop0);
        end
        while (exp_q.size() > 0) begin
            want = 8'(exp_q.pop_front());
            vectors++;
            if (fifo_data !== want) begin
                errors++;
                $display("FAIL wrap_drain got %h want %h", fifo_data, want);
            end
            pop = 1'b1; tick(); pop = 1'b0;
        end
        rx_data = 8'h3C; data_ready = 1'b1;
        tick();
        pop = 1'b1; tick(); pop = 1'b0;
        data_ready = 1'b0;
        vectors++;
        if (fifo_count !== 4'd1 || fifo_data !== 8'h3C) begin
            errors++;
            $display("FAIL empty_pushpop got cnt=%0d data=%h want 1 3c", fifo_count, fifo_data);
        end
        tick();
        pop = 1'b1; tick(); pop = 1'b0;
    endtask

    task automatic test_errors();
        clr_counts = 1'b1; tick(); clr_counts = 1'b0;
        for (int i = 0; i < 3; i++) begin
            framing_error = 1'b1; tick();
            framing_error = 1'b0; tick();
        end
        overrun_error = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        overrun_error = 1'b0; tick();
        vectors++;
        if (framing_err_cnt !== 8'd3 || overrun_cnt !== 8'd1) begin
            errors++;
            $display("FAIL err_counts got fe=%0d ov=%0d want 3 1", framing_err_cnt, overrun_cnt);
        end
        framing_error = 1'b1; clr_counts = 1'b1;
        tick();
        clr_counts = 1'b0;
        vectors++;
        if (framing_err_cnt !== 8'd0 || overrun_cnt !== 8'd0) begin
            errors++;
            $display("FAIL err_clr_prio got fe=%0d ov=%0d want 0 0", framing_err_cnt, overrun_cnt);
        end
        tick();
        framing_error = 1'b0; tick();
        for (int i = 0; i < 5; i++) begin
            framing_error = 1'b1; tick();
            framing_error = 1'b0; tick();
        end
        vectors++;
        if (s_fe !== 2'd3 || framing_err_cnt !== 8'd5) begin
            errors++;
            $display("FAIL err_saturate got narrow=%0d wide=%0d want 3 5", s_fe, framing_err_cnt);
        end
    endtask

    task automatic test_handshake_enable();
        rx_data = 8'h5A; data_ready = 1'b1;
        tick();
        vectors++;
        if (data_read !== 1'b1) begin
            errors++;
            $display("FAIL hs_ack got dr=%b want 1", data_read);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if (data_read !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL hs_wait[%0d] got dr=%b busy=%b want 0 1", i, data_read, busy);
            end
        end
        data_ready = 1'b0; tick();
        vectors++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL hs_release got busy=%b want 0", busy);
        end
        enable = 1'b0; data_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if (data_read !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL en_off[%0d] got dr=%b busy=%b want 0 0", i, data_read, busy);
            end
        end
        enable = 1'b1;
        tick();
        vectors++;
        if (data_read !== 1'b1) begin
            errors++;
            $display("FAIL en_on got dr=%b want 1", data_read);
        end
        data_ready = 1'b0;
        tick(); tick();
    endtask

    task automatic test_reset_midop();
        int p;
        for (int i = 0; i < 2 * DEPTH && fifo_count != 0; i++) begin
            pop = 1'b1; tick(); pop = 1'b0;
        end
        send_byte(8'h11, 1'b0, p);
        send_byte(8'h22, 1'b1, p);
        rx_data = 8'hC3; even_parity_bit = 1'b1; data_ready = 1'b1;
        tick(); tick();
        vectors++;
        if (fifo_count !== 4'd3 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre got cnt=%0d busy=%b want 3 1", fifo_count, busy);
        end
        #2 n_rst = 1'b0;
        #1;
        model_reset();
        vectors++;
        if ({data_read, busy, fifo_empty, fifo_full, fifo_count} !== 8'b0010_0000
            || {framing_err_cnt, overrun_cnt, drop_cnt} !== 24'd0) begin
            errors++;
            $display("FAIL rst_async got dr=%b busy=%b empty=%b cnt=%0d fe=%0d want 0 0 1 0 0",
                     data_read, busy, fifo_empty, fifo_count, framing_err_cnt);
        end
        @(negedge clk);
        n_rst = 1'b1;
        tick();
        vectors++;
        if (data_read !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_resume got dr=%b busy=%b want 1 1", data_read, busy);
        end
        data_ready = 1'b0;
        tick(); tick();
        vectors++;
        if (fifo_count !== 4'd1 || fifo_data !== 8'hC3 || fifo_parity !== 1'b1) begin
            errors++;
            $display("FAIL rst_newbyte got cnt=%0d data=%h par=%b want 1 c3 1",
                     fifo_count, fifo_data, fifo_parity);
        end
    endtask

    task automatic test_random();
        int pop_pct;
        logic [8:0] head;
        for (int c = 0; c < 2000; c++) begin
            head = (m_q.size() > 0) ? 9'(m_q[0]) : 9'd0;
            vectors++;
            if (data_read !== m_ack || busy !== m_busy) begin
                errors++;
                $display("FAIL rnd_fsm@%0d got dr=%b busy=%b want %b %b",
                         c, data_read, busy, m_ack, m_busy);
            end
            vectors++;
            if (fifo_count !== 4'(m_q.size()) || fifo_empty !== (m_q.size() == 0)
                || fifo_full !== (m_q.size() == DEPTH)) begin
                errors++;
                $display("FAIL rnd_level@%0d got cnt=%0d empty=%b full=%b want %0d",
                         c, fifo_count, fifo_empty, fifo_full, m_q.size());
            end
            if (m_q.size() > 0) begin
                vectors++;
                if ({fifo_parity, fifo_data} !== head) begin
                    errors++;
                    $display("FAIL rnd_head@%0d got %h want %h",
                             c, {fifo_parity, fifo_data}, head);
                end
            end
            vectors++;
            if (framing_err_cnt !== 8'(m_fe) || overrun_cnt !== 8'(m_ov)
                || drop_cnt !== 8'(m_drop)) begin
                errors++;
                $display("FAIL rnd_cnt@%0d got fe=%0d ov=%0d drop=%0d want %0d %0d %0d",
                         c, framing_err_cnt, overrun_cnt, drop_cnt, m_fe, m_ov, m_drop);
            end
            vectors++;
            if ({s_dr, s_busy, s_empty, s_full, s_count} !==
                    {m_ack, m_busy, m_q.size() == 0, m_q.size() == DEPTH, 4'(m_q.size())}
                || (m_q.size() > 0 && {s_par, s_data} !== head)
                || {s_fe, s_ov, s_drop} !== {2'(m_fe2), 2'(m_ov2), 2'(m_drop2)}) begin
                errors++;
                $display("FAIL rnd_narrow@%0d got cnt=%0d fe=%0d ov=%0d drop=%0d want %0d %0d %0d %0d",
                         c, s_count, s_fe, s_ov, s_drop, m_q.size(), m_fe2, m_ov2, m_drop2);
            end
            pop_pct = (c < 1000) ? 10 : 45;
            pop = ($urandom_range(0, 99) < pop_pct);
            enable = ($urandom_range(0, 9) != 0);
            clr_counts = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 3) == 0) framing_error = ~framing_error;
            if ($urandom_range(0, 9) == 0) overrun_error = ~overrun_error;
            if (!data_ready) begin
                if ($urandom_range(0, 99) < 40) begin
                    rx_data = 8'($urandom);
                    even_parity_bit = 1'($urandom);
                    data_ready = 1'b1;
                end
            end else if (m_busy && !m_ack) begin
                if ($urandom_range(0, 1) == 1) data_ready = 1'b0;
            end
            tick();
        end
        pop = 1'b0; clr_counts = 1'b0; data_ready = 1'b0;
        framing_error = 1'b0; overrun_error = 1'b0; enable = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_fill_overflow();
        test_wrap();
        test_errors();
        test_handshake_enable();
        test_reset_midop();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
